// File: rtl/imem_dmem_arbiter_pkg.sv
// imem_dmem_arbiter_pkg: shared state encodings, grant ids and default widths for the memory arbiter
package imem_dmem_arbiter_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;
  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_t;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating counter of MEM grants taken while a fetch waits
module arb_starve_ctr #(
  parameter int CNT_W = 3,
  parameter int MAX   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);
  assign sat = cnt == MAX_V;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 1'b1;
endmodule

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port memory bus between fetch and load/store,
// MEM priority with a starvation guard for fetch and redirect-driven fetch response discard
module imem_dmem_arbiter import imem_dmem_arbiter_pkg::*; #(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_valid,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_ready,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                stall_if,
  output logic                stall_mem
);
  state_t state, state_nx;
  gnt_t gnt;
  logic drop, sat, pick_if, pick_mem, if_acc, mem_acc, waiting;
  logic [CNT_W-1:0] starve_cnt;

  arb_starve_ctr #(.CNT_W(CNT_W), .MAX(STARVE_MAX)) u_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (mem_acc && if_req),
    .clr  (if_acc || !if_req),
    .cnt  (starve_cnt),
    .sat  (sat)
  );

  // Requests are only offered from IDLE, so bus_req never depends on bus_rvalid
  always_comb begin
    waiting   = state == ST_IF_WAIT || state == ST_MEM_WAIT;
    pick_if   = rst_n && state == ST_IDLE && if_req && (!mem_req || sat) && !if_flush;
    pick_mem  = rst_n && state == ST_IDLE && mem_req && !pick_if;
    gnt       = pick_if ? GNT_IF : GNT_MEM;
    bus_req   = pick_if || pick_mem;
    bus_addr  = !bus_req ? '0 : gnt == GNT_IF ? if_addr : mem_addr;
    bus_we    = pick_mem && mem_we;
    bus_wdata = bus_we ? mem_wdata : '0;
    bus_wstrb = bus_we ? mem_wstrb : '0;
    if_acc    = pick_if && bus_ready;
    mem_acc   = pick_mem && bus_ready;
    state_nx  = if_acc ? ST_IF_WAIT : mem_acc ? ST_MEM_WAIT :
                (state != ST_IDLE && (bus_rvalid || !waiting)) ? ST_IDLE : state;
    mem_valid = state == ST_MEM_WAIT && bus_rvalid;
    if_valid  = state == ST_IF_WAIT && bus_rvalid && !drop && !if_flush;
    mem_rdata = mem_valid ? bus_rdata : '0;
    if_rdata  = if_valid ? bus_rdata : '0;
    stall_if  = if_req && !if_valid;
    stall_mem = mem_req && !mem_valid;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_nx;
      drop  <= state == ST_IF_WAIT && !bus_rvalid && (drop || if_flush);
    end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: directed scenario bench for the fetch/load-store bus arbiter
module tb_imem_dmem_arbiter;
  import imem_dmem_arbiter_pkg::*;
  logic clk = 0, rst_n = 0;
  logic if_req = 0, if_flush = 0, if_valid;
  logic [31:0] if_addr = 0, if_rdata;
  logic mem_req = 0, mem_we = 0, mem_valid;
  logic [31:0] mem_addr = 0, mem_wdata = 0, mem_rdata;
  logic [3:0] mem_wstrb = 0, bus_wstrb;
  logic bus_req, bus_we, bus_ready = 0, bus_rvalid = 0;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = 0;
  logic stall_if, stall_mem;
  int n_checks = 0, n_fail = 0;

  imem_dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_valid(if_valid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    if_req = 0; if_flush = 0; mem_req = 0; mem_we = 0; mem_wstrb = 0;
    bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    if_req = 1; #1;
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req got %b want 0", bus_req); end
    n_checks++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL reset_stall_if got %b want 1", stall_if); end
    n_checks++; if ({if_valid, mem_valid, bus_addr, if_rdata} !== 66'd0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", {if_valid, mem_valid, bus_addr, if_rdata}); end
    n_checks++; if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want 0", dut.state); end
    if_req = 0; rst_n = 1;
    step;
  endtask

  task automatic test_fetch;
    if_req = 1; if_addr = 32'h100; bus_ready = 1; #1;
    n_checks++; if ({bus_req, bus_we, bus_addr, bus_wstrb} !== {2'b10, 32'h100, 4'h0}) begin n_fail++; $display("FAIL fetch_issue got %b %b %h %h want 1 0 100 0", bus_req, bus_we, bus_addr, bus_wstrb); end
    n_checks++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL fetch_stall got %b want 1", stall_if); end
    step;
    bus_ready = 0; bus_rvalid = 1; bus_rdata = 32'h00500093; #1;
    n_checks++; if ({if_valid, if_rdata} !== {1'b1, 32'h00500093}) begin n_fail++; $display("FAIL fetch_valid got %b %h want 1 00500093", if_valid, if_rdata); end
    n_checks++; if ({bus_req, stall_if} !== 2'b00) begin n_fail++; $display("FAIL fetch_rsp_flags got %b want 00", {bus_req, stall_if}); end
    step;
    idle_inputs; #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse got %b want 0", if_valid); end
  endtask

  task automatic test_contention;
    if_req = 1; if_addr = 32'h104; mem_req = 1; mem_we = 0; mem_addr = 32'h2000; mem_wstrb = 4'hF; bus_ready = 1; #1;
    n_checks++; if ({bus_req, bus_we, bus_addr, bus_wstrb} !== {2'b10, 32'h2000, 4'h0}) begin n_fail++; $display("FAIL cont_mem_first got %b %b %h %h want 1 0 2000 0", bus_req, bus_we, bus_addr, bus_wstrb); end
    step;
    bus_ready = 0; bus_rvalid = 1; bus_rdata = 32'h11223344; #1;
    n_checks++; if ({mem_valid, mem_rdata, if_valid} !== {1'b1, 32'h11223344, 1'b0}) begin n_fail++; $display("FAIL cont_mem_valid got %b %h %b want 1 11223344 0", mem_valid, mem_rdata, if_valid); end
    step;
    mem_req = 0; bus_rvalid = 0; bus_ready = 1; #1;
    n_checks++; if ({bus_req, bus_addr} !== {1'b1, 32'h104}) begin n_fail++; $display("FAIL cont_if_next got %b %h want 1 104", bus_req, bus_addr); end
    step;
    bus_ready = 0; bus_rvalid = 1; bus_rdata = 32'hCAFE0001; #1;
    n_checks++; if ({if_valid, if_rdata} !== {1'b1, 32'hCAFE0001}) begin n_fail++; $display("FAIL cont_if_valid got %b %h want 1 cafe0001", if_valid, if_rdata); end
    step;
    idle_inputs;
  endtask

  task automatic test_starvation;
    logic [31:0] exp_addr;
    if_req = 1; if_addr = 32'h400; mem_req = 1; mem_we = 0; mem_addr = 32'h5000;
    for (int g = 0; g < 5; g++) begin
      exp_addr = (g < 4) ? 32'h5000 : 32'h400;
      bus_ready = 1; bus_rvalid = 0; #1;
      n_checks++; if ({bus_req, bus_addr} !== {1'b1, exp_addr}) begin n_fail++; $display("FAIL starve_grant%0d got %b %h want 1 %h", g, bus_req, bus_addr, exp_addr); end
      step;
      bus_ready = 0; bus_rvalid = 1; bus_rdata = 32'h900 + g; #1;
      n_checks++; if ({mem_valid, if_valid} !== ((g < 4) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL starve_rsp%0d got %b want %b", g, {mem_valid, if_valid}, (g < 4) ? 2'b10 : 2'b01); end
      if (g == 3) begin
        n_checks++; if (dut.starve_cnt !== 3'd4) begin n_fail++; $display("FAIL starve_sat got %0d want 4", dut.starve_cnt); end
      end
      step;
    end
    n_checks++; if (dut.starve_cnt !== 3'd0) begin n_fail++; $display("FAIL starve_clear got %0d want 0", dut.starve_cnt); end
    idle_inputs;
  endtask

  task automatic test_store;
    mem_req = 1; mem_we = 1; mem_addr = 32'h3000; mem_wstrb = 4'b0011; mem_wdata = 32'hDEADBEEF; bus_ready = 0;
    step;
    #1;
    n_checks++; if ({bus_req, stall_mem, dut.state} !== {2'b11, ST_IDLE}) begin n_fail++; $display("FAIL store_backpressure got %b %b %0d want 1 1 0", bus_req, stall_mem, dut.state); end
    bus_ready = 1; #1;
    n_checks++; if ({bus_we, bus_wstrb, bus_wdata, bus_addr} !== {1'b1, 4'b0011, 32'hDEADBEEF, 32'h3000}) begin n_fail++; $display("FAIL store_bus got %b %b %h %h want 1 0011 deadbeef 3000", bus_we, bus_wstrb, bus_wdata, bus_addr); end
    step;
    bus_ready = 0; bus_rvalid = 1; #1;
    n_checks++; if ({mem_valid, stall_mem} !== 2'b10) begin n_fail++; $display("FAIL store_ack got %b want 10", {mem_valid, stall_mem}); end
    step;
    idle_inputs;
  endtask

  task automatic test_flush;
    if_req = 1; if_flush = 1; if_addr = 32'h200; bus_ready = 1; #1;
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL flush_idle_block got %b want 0", bus_req); end
    if_flush = 0; #1;
    step;
    bus_ready = 0; if_flush = 1; #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wait got %b want 0", if_valid); end
    step;
    if_flush = 0; if_addr = 32'h300; bus_rvalid = 1; bus_rdata = 32'hBAD0BAD0; #1;
    n_checks++; if ({if_valid, bus_req} !== 2'b00) begin n_fail++; $display("FAIL flush_swallow got %b want 00", {if_valid, bus_req}); end
    step;
    bus_rvalid = 0; bus_ready = 1; #1;
    n_checks++; if ({bus_req, bus_addr} !== {1'b1, 32'h300}) begin n_fail++; $display("FAIL flush_refetch got %b %h want 1 300", bus_req, bus_addr); end
    step;
    bus_ready = 0; bus_rvalid = 1; bus_rdata = 32'h0000AAAA; #1;
    n_checks++; if ({if_valid, if_rdata} !== {1'b1, 32'h0000AAAA}) begin n_fail++; $display("FAIL flush_new_valid got %b %h want 1 0000aaaa", if_valid, if_rdata); end
    step;
    bus_rvalid = 0; bus_ready = 1; if_addr = 32'h304; #1;
    step;
    bus_ready = 0; bus_rvalid = 1; if_flush = 1; #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL flush_coincident got %b want 0", if_valid); end
    step;
    idle_inputs;
  endtask

  task automatic test_reset_mid;
    mem_req = 1; mem_addr = 32'h6000; bus_ready = 1;
    step;
    bus_ready = 0; #1;
    n_checks++; if (dut.state !== ST_MEM_WAIT) begin n_fail++; $display("FAIL rmid_wait got %0d want 2", dut.state); end
    rst_n = 0; mem_req = 0; #1;
    n_checks++; if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL rmid_state got %0d want 0", dut.state); end
    step;
    rst_n = 1; bus_rvalid = 1; bus_rdata = 32'h12345678; #1;
    n_checks++; if ({mem_valid, if_valid, bus_req, mem_rdata, bus_addr} !== 67'd0) begin n_fail++; $display("FAIL rmid_outputs got %h want 0", {mem_valid, if_valid, bus_req, mem_rdata, bus_addr}); end
    step;
    idle_inputs;
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_contention;
    test_starvation;
    test_store;
    test_flush;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port unified memory bus between the fetch stage (IF) and the load/store stage (MEM) of the 5-stage pipeline.
- Allows one outstanding bus transaction at a time.
- Data requests have fixed priority. A starvation counter guarantees fetch progress.
- Produces per-stage stall signals that the pipeline control combines with the load-use/branch hazard stall. Fetch responses can be discarded on branch redirect.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive MEM grants allowed while IF waits; the next grant goes to IF
- CNT_W, 3, starvation counter width (must hold STARVE_MAX)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- if_req  in  1  fetch request, level; held until if_valid
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_flush  in  1  branch/jump redirect; kills the in-flight fetch
- if_valid  out  1  1-cycle pulse: fetch data valid
- if_rdata  out  DATA_W  fetch data, valid with if_valid
- mem_req  in  1  load/store request, level; held until mem_valid
- mem_we  in  1  1 = store
- mem_addr  in  ADDR_W  load/store address
- mem_wdata  in  DATA_W  store data
- mem_wstrb  in  DATA_W/8  byte strobes for stores
- mem_valid  out  1  1-cycle pulse: load data valid / store complete
- mem_rdata  out  DATA_W  load data
- bus_req  out  1  bus request
- bus_we  out  1  bus write enable
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_wstrb  out  DATA_W/8  bus write strobes; 0 for fetches and loads
- bus_ready  in  1  bus accepts request this cycle (bus_req & bus_ready = accept)
- bus_rvalid  in  1  response/ack; at least 1 cycle after accept
- bus_rdata  in  DATA_W  response data
- stall_if  out  1  if_req & ~if_valid
- stall_mem  out  1  mem_req & ~mem_valid

Behaviour:
- States:
  - IDLE: no transaction outstanding.
  - IF_WAIT: fetch accepted, awaiting response.
  - MEM_WAIT: load/store accepted, awaiting response.
  - Encoding 2 bits.
- Reset (async, rst_n=0):
  - State IDLE, starve_cnt=0, drop=0.
  - All outputs 0 except the stalls, which follow their combinational definition.
  - Reset mid-transaction abandons it. A bus_rvalid arriving in IDLE is ignored.
- IDLE arbitration (combinational):
  - pick_if = if_req & (~mem_req | starve_cnt==STARVE_MAX) & ~if_flush.
  - pick_mem = mem_req & ~pick_if.
  - bus_req = pick_if|pick_mem; bus_addr/we/wdata/wstrb are muxed from the picked requester.
  - On bus_ready, the FSM moves to IF_WAIT or MEM_WAIT. Without bus_ready it stays in IDLE and re-arbitrates next cycle; the pick may change.
- In IF_WAIT/MEM_WAIT: bus_req=0. On bus_rvalid the FSM returns to IDLE; a new issue is possible the next cycle.
  - MEM_WAIT & bus_rvalid: mem_valid=1, mem_rdata=bus_rdata, same cycle.
  - IF_WAIT & bus_rvalid & ~drop & ~if_flush: if_valid=1, if_rdata=bus_rdata, same cycle.
- Latency: minimum 2 cycles from request to valid (accept in cycle N, rvalid in N+1 or later, valid in the same cycle as rvalid).
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each MEM accept while if_req=1.
  - Cleared on IF accept, or when if_req=0.
- Flush:
  - if_flush in IF_WAIT sets drop=1. The matching response is swallowed (no if_valid), then drop is cleared.
  - if_flush coincident with bus_rvalid also swallows the response.
  - if_flush in IDLE blocks IF selection that cycle only.
  - Flush never affects MEM transactions.
- Simultaneous if_req and mem_req with starve_cnt<STARVE_MAX: MEM wins.
- No combinational path from bus_rvalid to bus_req.

Decomposition:
- Shared pipeline package holds:
  - state encodings ST_IDLE=2'd0, ST_IF_WAIT=2'd1, ST_MEM_WAIT=2'd2
  - grant constants GNT_IF/GNT_MEM
  - default ADDR_W/DATA_W
- One sub-module: arb_starve_ctr (saturating counter with inc/clr/sat outputs).
- The request mux and FSM stay in the top level.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100; bus_ready same cycle; bus_rvalid 1 cycle later with 0x00500093 -> if_valid pulses once with if_rdata=0x00500093; stall_if=1 until that cycle.
- Contention: if_req and mem_req (load 0x2000) both asserted in IDLE -> MEM granted first (bus_addr=0x2000, bus_wstrb=0); IF is granted right after mem_valid.
- Starvation: mem_req held continuously, if_req held, bus responds in 1 cycle -> after exactly 4 MEM accepts, the 5th accept is IF; counter reads 0 after.
- Store: mem_we=1, mem_wstrb=4'b0011, wdata=0xDEADBEEF -> bus_we=1, bus_wstrb=0011, bus_wdata=0xDEADBEEF; mem_valid on ack.
- Flush: fetch accepted, if_flush pulsed before bus_rvalid -> no if_valid for that response; next fetch to new address completes normally.
- Reset mid-transaction: rst_n low during MEM_WAIT, then late bus_rvalid -> no mem_valid, state IDLE, all outputs 0.
